// File: rtl/external_pin_debounce_if.sv
// external_pin_debounce_if: pin-side and core-side signals of one debounced ExternalPin.
interface external_pin_debounce_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] pin_in, pin_out, out_write_v, stable, change_mask;
    logic             out_write__ENA, out_write__RDY, change__RDY, change__ENA, change_overrun;
    logic [15:0]      glitch_count;
    modport master (
        output pin_in, out_write__ENA, out_write_v, change__ENA,
        input  pin_out, out_write__RDY, stable, change__RDY, change_mask, change_overrun, glitch_count
    );
    modport slave (
        input  pin_in, out_write__ENA, out_write_v, change__ENA,
        output pin_out, out_write__RDY, stable, change__RDY, change_mask, change_overrun, glitch_count
    );
endinterface

// File: rtl/external_pin_debounce.sv
// external_pin_debounce: synchronise and debounce an ExternalPin bus, queue change events, drive pin_out.
// Define EXTERNAL_PIN_DEBOUNCE_GLITCH_COUNT_EN to build the saturating glitch counter.
module external_pin_debounce #(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic                  CLK,
    input logic                  nRST,
    external_pin_debounce_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]                  s, stable_q, flip, mask_q, pout_q;
    logic                              rdy_q, ovr_q, ack;

    assign s   = sync_q[SYNC_STAGES-1];
    assign ack = bus.change__ENA & rdy_q;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            flip[i]  = s[i] != stable_q[i] && cnt_q[i] == LAST;
            cnt_d[i] = (s[i] == stable_q[i] || flip[i]) ? '0 : cnt_q[i] + CW'(1);
        end
    end

    // flip only fires on a mismatch, so toggling stable is the same as loading s
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            rdy_q    <= 1'b0;
            mask_q   <= '0;
            ovr_q    <= 1'b0;
            pout_q   <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.pin_in};
            cnt_q    <= cnt_d;
            stable_q <= stable_q ^ flip;
            rdy_q    <= (rdy_q & ~ack) | (|flip);
            mask_q   <= (ack ? '0 : mask_q) | flip;
            ovr_q    <= (ack ? 1'b0 : ovr_q) | (|(flip & mask_q & ~{WIDTH{ack}}));
            if (bus.out_write__ENA) pout_q <= bus.out_write_v;
        end
    end

`ifdef EXTERNAL_PIN_DEBOUNCE_GLITCH_COUNT_EN
    logic [WIDTH-1:0] glitch;
    logic [15:0]      gcnt_q;
    always_comb begin
        for (int i = 0; i < WIDTH; i++) glitch[i] = s[i] == stable_q[i] && cnt_q[i] != '0;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) gcnt_q <= '0;
        else if (|glitch && gcnt_q != 16'hFFFF) gcnt_q <= gcnt_q + 16'd1;
    end
    assign bus.glitch_count = gcnt_q;
`else
    assign bus.glitch_count = '0;
`endif

    assign bus.pin_out        = pout_q;
    assign bus.out_write__RDY = 1'b1;
    assign bus.stable         = stable_q;
    assign bus.change__RDY    = rdy_q;
    assign bus.change_mask    = mask_q;
    assign bus.change_overrun = ovr_q;
endmodule

// File: tb/tb_external_pin_debounce.sv
// tb_external_pin_debounce: directed vector table, corner sequences and randomized run against a history-based model.
module tb_external_pin_debounce;
    localparam int W = 4, SS = 2, DC = 4;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int tests = 0, fails = 0, proto = 0;
    always #5 CLK = ~CLK;

    external_pin_debounce_if #(.WIDTH(W)) bus();
    external_pin_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus)
    );

    // Model: a pin level is accepted once the last DC synchronised samples all disagree with stable.
    typedef struct packed {
        logic [SS-1:0][W-1:0] pipe;
        logic [DC-1:0][W-1:0] hist;
        logic [W-1:0] stable, mask, pout;
        logic rdy, ovr;
        logic [15:0] gc;
    } model_t;
    model_t m;

    function automatic model_t step(model_t c, logic [W-1:0] pin, logic ena, logic wen, logic [W-1:0] wv);
        model_t n = c;
        logic [W-1:0] fl = '0, gl = '0;
        logic ack = ena & c.rdy;
        int run, prior;
        bit going;
        n.pipe = {c.pipe[SS-2:0], pin};
        n.hist = {c.hist[DC-2:0], c.pipe[SS-1]};
        for (int i = 0; i < W; i++) begin
            run = 0; going = 1;
            for (int j = 0; j < DC; j++)
                if (going && n.hist[j][i] != c.stable[i]) run++; else going = 0;
            prior = 0; going = 1;
            for (int j = 1; j < DC; j++)
                if (going && n.hist[j][i] != c.stable[i]) prior++; else going = 0;
            fl[i] = run == DC;
            gl[i] = n.hist[0][i] == c.stable[i] && prior > 0;
        end
        n.stable = c.stable ^ fl;
        n.rdy    = (c.rdy && !ack) || fl != '0;
        n.mask   = (ack ? '0 : c.mask) | fl;
        n.ovr    = (!ack && c.ovr) || (!ack && (fl & c.mask) != '0);
`ifdef EXTERNAL_PIN_DEBOUNCE_GLITCH_COUNT_EN
        if (gl != '0 && c.gc != 16'hFFFF) n.gc = c.gc + 16'd1;
`else
        n.gc = gl == '0 ? 16'd0 : 16'd0;
`endif
        if (wen) n.pout = wv;
        return n;
    endfunction

    always @(posedge CLK or negedge nRST)
        if (!nRST) m <= '0;
        else m <= step(m, bus.pin_in, bus.change__ENA, bus.out_write__ENA, bus.out_write_v);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] pin;
        logic         ena, wen;
        logic [W-1:0] wv;
        int           n;
        logic [W-1:0] e_stable;
        logic         e_rdy;
        logic [W-1:0] e_mask;
        logic         e_ovr;
        logic [W-1:0] e_pout;
    } vec_t;
    vec_t tbl[$];

`ifdef EXTERNAL_PIN_DEBOUNCE_GLITCH_COUNT_EN
    localparam logic [15:0] GC1 = 16'd1;
`else
    localparam logic [15:0] GC1 = 16'd0;
`endif

    initial begin
        tbl.push_back('{4'b0001, 0, 0, 4'h0, 5, 4'b0000, 0, 4'b0000, 0, 4'h0});
        tbl.push_back('{4'b0001, 0, 0, 4'h0, 1, 4'b0001, 1, 4'b0001, 0, 4'h0});
        tbl.push_back('{4'b0001, 1, 0, 4'h0, 1, 4'b0001, 0, 4'b0000, 0, 4'h0});
        tbl.push_back('{4'b0000, 0, 0, 4'h0, 6, 4'b0000, 1, 4'b0001, 0, 4'h0});
        tbl.push_back('{4'b0000, 1, 0, 4'h0, 1, 4'b0000, 0, 4'b0000, 0, 4'h0});
        tbl.push_back('{4'b0001, 0, 0, 4'h0, 6, 4'b0001, 1, 4'b0001, 0, 4'h0});
        tbl.push_back('{4'b0101, 0, 0, 4'h0, 6, 4'b0101, 1, 4'b0101, 0, 4'h0});
        tbl.push_back('{4'b0100, 0, 0, 4'h0, 6, 4'b0100, 1, 4'b0101, 1, 4'h0});
        tbl.push_back('{4'b0100, 1, 0, 4'h0, 1, 4'b0100, 0, 4'b0000, 0, 4'h0});
        tbl.push_back('{4'b0000, 0, 0, 4'h0, 6, 4'b0000, 1, 4'b0100, 0, 4'h0});
        tbl.push_back('{4'b1000, 0, 0, 4'h0, 5, 4'b0000, 1, 4'b0100, 0, 4'h0});
        tbl.push_back('{4'b1000, 1, 0, 4'h0, 1, 4'b1000, 1, 4'b1000, 0, 4'h0});
        tbl.push_back('{4'b1000, 1, 0, 4'h0, 1, 4'b1000, 0, 4'b0000, 0, 4'h0});
        tbl.push_back('{4'b1001, 0, 1, 4'hA, 1, 4'b1000, 0, 4'b0000, 0, 4'hA});
        tbl.push_back('{4'b1001, 0, 1, 4'h5, 1, 4'b1000, 0, 4'b0000, 0, 4'h5});
        tbl.push_back('{4'b1001, 0, 0, 4'h0, 3, 4'b1000, 0, 4'b0000, 0, 4'h5});
        tbl.push_back('{4'b1001, 0, 0, 4'h0, 1, 4'b1001, 1, 4'b0001, 0, 4'h5});

        bus.pin_in = '0; bus.change__ENA = 0; bus.out_write__ENA = 0; bus.out_write_v = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK) nRST = 1'b1;

        foreach (tbl[k]) begin
            bus.pin_in = tbl[k].pin; bus.change__ENA = tbl[k].ena;
            bus.out_write__ENA = tbl[k].wen; bus.out_write_v = tbl[k].wv;
            repeat (tbl[k].n) @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("vec%0d_stable", k), 32'(bus.stable), 32'(tbl[k].e_stable));
            chk($sformatf("vec%0d_rdy", k), 32'(bus.change__RDY), 32'(tbl[k].e_rdy));
            chk($sformatf("vec%0d_mask", k), 32'(bus.change_mask), 32'(tbl[k].e_mask));
            chk($sformatf("vec%0d_ovr", k), 32'(bus.change_overrun), 32'(tbl[k].e_ovr));
            chk($sformatf("vec%0d_pout", k), 32'(bus.pin_out), 32'(tbl[k].e_pout));
        end
        bus.change__ENA = 0; bus.out_write__ENA = 0;

        // async reset mid-cycle with event pending, pin_out driven and counters running
        bus.pin_in = 4'b0110;
        repeat (3) @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("rst_stable", 32'(bus.stable), 32'h0);
        chk("rst_rdy", 32'(bus.change__RDY), 32'h0);
        chk("rst_mask", 32'(bus.change_mask), 32'h0);
        chk("rst_ovr", 32'(bus.change_overrun), 32'h0);
        chk("rst_pout", 32'(bus.pin_out), 32'h0);
        chk("rst_gc", 32'(bus.glitch_count), 32'h0);
        chk("rst_wrdy", 32'(bus.out_write__RDY), 32'h1);
        @(negedge CLK) bus.pin_in = '0;
        @(posedge CLK) #1;
        chk("rst_hold_stable", 32'(bus.stable), 32'h0);
        @(negedge CLK) nRST = 1'b1;

        // 3-cycle pulse on bit1 is a glitch
        bus.pin_in = 4'b0010;
        repeat (3) @(posedge CLK);
        @(negedge CLK) bus.pin_in = 4'b0000;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("glitch_stable", 32'(bus.stable), 32'h0);
        chk("glitch_rdy", 32'(bus.change__RDY), 32'h0);
        chk("glitch_count", 32'(bus.glitch_count), 32'(GC1));

        // 4-cycle pulse is just long enough to be accepted
        bus.pin_in = 4'b0010;
        repeat (4) @(posedge CLK);
        @(negedge CLK) bus.pin_in = 4'b0000;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("accept_stable", 32'(bus.stable), 32'h2);
        chk("accept_rdy", 32'(bus.change__RDY), 32'h1);
        chk("accept_mask", 32'(bus.change_mask), 32'h2);
        chk("accept_gc", 32'(bus.glitch_count), 32'(GC1));

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) bus.pin_in = bus.pin_in ^ W'($urandom_range(1, 15));
            bus.change__ENA    = $urandom_range(0, 3) == 0;
            bus.out_write__ENA = $urandom_range(0, 3) == 0;
            bus.out_write_v    = W'($urandom_range(0, 15));
            if (bus.change__ENA && !m.rdy) proto++;
            @(posedge CLK);
            @(negedge CLK);
            chk("rnd_stable", 32'(bus.stable), 32'(m.stable));
            chk("rnd_rdy", 32'(bus.change__RDY), 32'(m.rdy));
            chk("rnd_mask", 32'(bus.change_mask), 32'(m.mask));
            chk("rnd_ovr", 32'(bus.change_overrun), 32'(m.ovr));
            chk("rnd_pout", 32'(bus.pin_out), 32'(m.pout));
            chk("rnd_gc", 32'(bus.glitch_count), 32'(m.gc));
        end
        bus.change__ENA = 0; bus.out_write__ENA = 0;
        $display("[TB] note: %0d protocol errors (change__ENA while idle) driven and ignored", proto);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/external_pin_debounce.md
Name: external_pin_debounce

Overview:
- Input-conditioning stage directly downstream of an ExternalPinIFC server.
- Synchronises the raw `in` bus and debounces each bit independently.
- Presents debounced bit-level change events to the core through a one-entry ready/enable event register.
- Also owns the registered `out` drive back to the pins, so one instance fully terminates one ExternalPin.

Parameters:
WIDTH, 32, pin bus width (matches ExternalPinIFC width)
SYNC_STAGES, 2, synchroniser flop depth; legal >= 2
DEBOUNCE_CYCLES, 16, consecutive mismatching cycles before a bit is accepted; legal >= 1; counter width $clog2(DEBOUNCE_CYCLES+1)

Ports:
CLK  input  1  sole clock
nRST  input  1  asynchronous, active-low reset
pin_in  input  WIDTH  raw asynchronous pin levels (ExternalPinIFC in)
pin_out  output  WIDTH  registered pin drive (ExternalPinIFC out)
out_write__ENA  input  1  load pin_out
out_write_v  input  WIDTH  value for pin_out
out_write__RDY  output  1  constant 1
stable  output  WIDTH  current debounced levels
change__RDY  output  1  event pending
change__ENA  input  1  consumer dequeues event
change_mask  output  WIDTH  bits that flipped since last dequeue
change_overrun  output  1  some bit flipped again while its mask bit was set
glitch_count  output  16  rejected-pulse counter (optional feature)

Behaviour:
- Reset (nRST low, asynchronous, takes effect immediately, holds while low):
  - synchroniser flops, stable, debounce counters, change_mask, change__RDY, change_overrun, pin_out and glitch_count all go to 0.
  - out_write__RDY is 1 during reset.
- Synchroniser: pin_in passes through SYNC_STAGES flops per bit. s[i] is the last stage. There is no debouncing inside the synchroniser.
- Per-bit debounce, bit i, evaluated every edge:
  - s[i]==stable[i]: cnt[i] <= 0.
  - s[i]!=stable[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i]!=stable[i] and cnt[i]==DEBOUNCE_CYCLES-1: stable[i] <= s[i]; cnt[i] <= 0; flip[i]=1 for this edge.
  - DEBOUNCE_CYCLES=1: a single mismatching cycle is accepted.
- Latency: a level change on pin_in sampled at edge 0 and held appears on stable and change__RDY after exactly SYNC_STAGES+DEBOUNCE_CYCLES edges.
- Glitch definition: s[i] returns to stable[i] while cnt[i] is nonzero. The counter clears, stable is unchanged and no event is raised.
- Event register, flip = OR-vector of flip[i] this edge, ack = change__ENA & change__RDY:
  - change__RDY <= (change__RDY & ~ack) | (|flip).
  - change_mask <= (ack ? 0 : change_mask) | flip.
  - change_overrun <= (ack ? 0 : change_overrun) | (|(flip & change_mask & ~{WIDTH{ack}})).
  - When ack and a new flip land on the same edge, the new flip survives: RDY stays 1 and the mask holds only the new bits.
  - change__ENA while change__RDY==0 is ignored. The bench flags it as a protocol error.
  - stable is live and is not frozen while an event is pending.
- Output path:
  - out_write__ENA loads pin_out <= out_write_v on the next edge, no stall.
  - pin_out is not affected by pin_in; any loopback is external.
- Simultaneous flips on multiple bits produce one event with multiple mask bits.

Optional Feature:
- Macro: EXTERNAL_PIN_DEBOUNCE_GLITCH_COUNT_EN.
- Defined:
  - glitch_count increments by 1 per edge on which at least one bit registers a glitch, saturating at 16'hFFFF.
  - Several bits glitching on the same edge count once.
  - Cleared only by reset.
- Undefined: no counter logic is built; glitch_count is tied to 0 and the port remains for interface stability.

Test Plan:
1. WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4; assert nRST low mid-cycle with all state nonzero -> all outputs 0 before the next CLK edge; out_write__RDY=1.
2. pin_in 4'b0000->4'b0001 held -> change__RDY=1 exactly 6 edges later; stable=4'b0001, change_mask=4'b0001, overrun=0; change__ENA one cycle -> RDY=0, mask=0.
3. Bit1 pulsed high for 3 cycles (under 4) -> stable unchanged and no event; glitch_count=1 with the macro defined, 0 without it.
4. Event pending on bit0 with no ack; bit2 debounces -> mask=4'b0101, overrun=0; bit0 then debounces back low -> overrun=1, stable=4'b0100; ack -> mask=0, overrun=0.
5. change__ENA asserted on the same edge that bit3 flips -> change__RDY stays 1, change_mask=4'b1000, overrun=0.
6. out_write__ENA with v=4'hA, then v=4'h5 on consecutive cycles -> pin_out=4'hA then 4'h5, one edge after each; debounce activity unaffected.
